// File: rtl/fetch_align_ifid.sv
// fetch_align_ifid
//   Instruction-fetch aligner plus IF/ID pipeline register for an RV32IC core.
//   Fetches aligned 32-bit words and reassembles 16-bit compressed and 32-bit
//   instructions, including 32-bit instructions that straddle a word boundary.
//   One instruction per cycle is handed to ID.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active low
//   imem_addr_o    registered word-aligned fetch address
//   imem_data_i    instruction word at imem_addr_o (same-cycle combinational)
//   stall_i        load-use stall: freeze fetch state and IF/ID
//   flush_i        IF/ID flush: load a bubble into IF/ID
//   redirect_i     taken branch/jump from ID
//   redirect_pc_i  halfword-aligned redirect target (bit 0 ignored)
//   instr_o        IF/ID instruction (compressed ones zero-extended)
//   pc_o           IF/ID instruction PC
//   compressed_o   instr_o holds a 16-bit instruction
//   valid_o        IF/ID holds a real instruction
module fetch_align_ifid #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        compressed_o,
  output logic        valid_o
);

  // Fetch state
  logic [31:0] fa_q, fa_d;
  logic [15:0] hb_q, hb_d;
  logic [31:0] hb_pc_q, hb_pc_d;
  logic        hb_v_q, hb_v_d;
  logic        skip_q, skip_d;

  // IF/ID register
  logic [31:0] instr_q, pc_q;
  logic        c_q, valid_q;

  // Candidate instruction produced by this cycle's alignment step
  logic        iss;
  logic [31:0] iss_instr, iss_pc;
  logic        iss_c;

  logic [31:0] fa_p2, fa_p4;
  logic        lo_c, hi_c, hb_c;

  // Halfword alignment of the redirect target is the caller's responsibility.
  logic unused_redirect_b0;
  assign unused_redirect_b0 = redirect_pc_i[0];

  assign fa_p2 = fa_q + 32'd2;
  assign fa_p4 = fa_q + 32'd4;
  assign lo_c  = (imem_data_i[1:0]   != 2'b11);
  assign hi_c  = (imem_data_i[17:16] != 2'b11);
  assign hb_c  = (hb_q[1:0]          != 2'b11);

  always_comb begin
    fa_d      = fa_q;
    hb_d      = hb_q;
    hb_pc_d   = hb_pc_q;
    hb_v_d    = hb_v_q;
    skip_d    = skip_q;
    iss       = 1'b0;
    iss_instr = BUBBLE_INSTR;
    iss_pc    = 32'h0;
    iss_c     = 1'b0;

    if (hb_v_q) begin
      iss    = 1'b1;
      iss_pc = hb_pc_q;
      if (hb_c) begin
        // Buffered compressed instruction; the current word is left for next cycle.
        iss_instr = {16'h0, hb_q};
        iss_c     = 1'b1;
        hb_v_d    = 1'b0;
      end else begin
        // Straddling 32-bit instruction; the new upper half becomes the residue.
        iss_instr = {imem_data_i[15:0], hb_q};
        hb_d      = imem_data_i[31:16];
        hb_pc_d   = fa_p2;
        fa_d      = fa_p4;
      end
    end else if (skip_q) begin
      skip_d = 1'b0;
      fa_d   = fa_p4;
      if (hi_c) begin
        iss       = 1'b1;
        iss_instr = {16'h0, imem_data_i[31:16]};
        iss_pc    = fa_p2;
        iss_c     = 1'b1;
      end else begin
        // 32-bit head in the upper half: buffer it, costs one bubble.
        hb_d    = imem_data_i[31:16];
        hb_pc_d = fa_p2;
        hb_v_d  = 1'b1;
      end
    end else begin
      iss    = 1'b1;
      iss_pc = fa_q;
      fa_d   = fa_p4;
      if (lo_c) begin
        iss_instr = {16'h0, imem_data_i[15:0]};
        iss_c     = 1'b1;
        hb_d      = imem_data_i[31:16];
        hb_pc_d   = fa_p2;
        hb_v_d    = 1'b1;
      end else begin
        iss_instr = imem_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fa_q    <= {RESET_PC[31:2], 2'b00};
      skip_q  <= RESET_PC[1];
      hb_q    <= 16'h0;
      hb_pc_q <= 32'h0;
      hb_v_q  <= 1'b0;
      instr_q <= BUBBLE_INSTR;
      pc_q    <= 32'h0;
      c_q     <= 1'b0;
      valid_q <= 1'b0;
    end else if (redirect_i) begin
      fa_q    <= {redirect_pc_i[31:2], 2'b00};
      skip_q  <= redirect_pc_i[1];
      hb_v_q  <= 1'b0;
      instr_q <= BUBBLE_INSTR;
      pc_q    <= 32'h0;
      c_q     <= 1'b0;
      valid_q <= 1'b0;
    end else if (stall_i) begin
      // Fetch state holds; flush may still squash the held IF/ID entry.
      if (flush_i) begin
        instr_q <= BUBBLE_INSTR;
        pc_q    <= 32'h0;
        c_q     <= 1'b0;
        valid_q <= 1'b0;
      end
    end else begin
      fa_q    <= fa_d;
      skip_q  <= skip_d;
      hb_q    <= hb_d;
      hb_pc_q <= hb_pc_d;
      hb_v_q  <= hb_v_d;
      if (flush_i || !iss) begin
        instr_q <= BUBBLE_INSTR;
        pc_q    <= 32'h0;
        c_q     <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        instr_q <= iss_instr;
        pc_q    <= iss_pc;
        c_q     <= iss_c;
        valid_q <= 1'b1;
      end
    end
  end

  assign imem_addr_o  = fa_q;
  assign instr_o      = instr_q;
  assign pc_o         = pc_q;
  assign compressed_o = c_q;
  assign valid_o      = valid_q;

endmodule

// File: tb/tb_fetch_align_ifid.sv
module tb_fetch_align_ifid;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] BUBBLE   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr, imem_data;
  logic        stall = 1'b0, flush = 1'b0, redir = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic [31:0] instr, pc;
  logic        comp, valid;

  logic [31:0] mem [64];
  assign imem_data = mem[imem_addr[7:2]];

  int tests_run = 0;
  int failed = 0;

  fetch_align_ifid #(.RESET_PC(RESET_PC), .BUBBLE_INSTR(BUBBLE)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_addr_o(imem_addr), .imem_data_i(imem_data),
    .stall_i(stall), .flush_i(flush),
    .redirect_i(redir), .redirect_pc_i(rpc),
    .instr_o(instr), .pc_o(pc), .compressed_o(comp), .valid_o(valid)
  );

  always #5 clk = ~clk;

  // Reference model: the program is a stream of instructions starting at m_pc.
  // Each cycle either one instruction (length from its first halfword) leaves
  // the stream, or a bubble is produced.
  logic [31:0] m_pc;
  logic        m_nb;      // one bubble owed: target was an upper-half 32-bit head
  logic        e_valid, e_c;
  logic [31:0] e_instr, e_pc;

  function automatic logic [15:0] half(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[7:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic model_jump(input logic [31:0] target);
    m_pc    = {target[31:1], 1'b0};
    m_nb    = m_pc[1] && (half(m_pc)[1:0] == 2'b11);
    e_valid = 1'b0;
    e_instr = BUBBLE;
  endtask

  task automatic model_edge(input logic st, input logic fl, input logic rd, input logic [31:0] t);
    logic [15:0] h0;
    if (rd) begin
      model_jump(t);
    end else if (st) begin
      if (fl) begin e_valid = 1'b0; e_instr = BUBBLE; end
    end else if (m_nb) begin
      m_nb = 1'b0; e_valid = 1'b0; e_instr = BUBBLE;
    end else begin
      h0 = half(m_pc);
      if (fl) begin
        e_valid = 1'b0; e_instr = BUBBLE;
      end else begin
        e_valid = 1'b1;
        e_pc    = m_pc;
        e_c     = (h0[1:0] != 2'b11);
        e_instr = e_c ? {16'h0, h0} : {half(m_pc + 32'd2), h0};
      end
      m_pc = m_pc + ((h0[1:0] != 2'b11) ? 32'd2 : 32'd4);
    end
  endtask

  task automatic cyc(input logic st, input logic fl, input logic rd, input logic [31:0] t);
    stall = st; flush = fl; redir = rd; rpc = t;
    model_edge(st, fl, rd, t);
    @(posedge clk); #1;
    stall = 1'b0; flush = 1'b0; redir = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    model_jump(RESET_PC);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [97:0] got, want;

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    got  = {valid, comp, pc, instr, imem_addr};
    want = {1'b0, 1'b0, 32'h0, BUBBLE, RESET_PC};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL reset: got %h want %h", got, want); end
  endtask

  task automatic test_stream32();
    logic [31:0] w [3];
    w[0] = 32'h0000_0513; w[1] = 32'h0040_0093; w[2] = 32'h0080_0113;
    for (int i = 0; i < 3; i++) mem[i] = w[i];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      got  = {valid, comp, pc, instr, imem_addr};
      want = {1'b1, 1'b0, 32'(4 * i), w[i], 32'(4 * i + 4)};
      tests_run++;
      if (got !== want) begin failed++; $display("FAIL stream32_%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_two_c();
    mem[0] = 32'h4505_4501;
    do_reset();
    cyc(0, 0, 0, 0);
    got  = {valid, comp, pc, instr, imem_addr};
    want = {1'b1, 1'b1, 32'h0, 32'h0000_4501, 32'h4};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL two_c_lo: got %h want %h", got, want); end
    cyc(0, 0, 0, 0);
    got  = {valid, comp, pc, instr, imem_addr};
    want = {1'b1, 1'b1, 32'h2, 32'h0000_4505, 32'h4};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL two_c_hi: got %h want %h", got, want); end
  endtask

  task automatic test_straddle();
    mem[0] = 32'h0513_4501;
    mem[1] = 32'h4505_0000;
    do_reset();
    cyc(0, 0, 0, 0);
    got  = {valid, comp, pc, instr, imem_addr};
    want = {1'b1, 1'b1, 32'h0, 32'h0000_4501, 32'h4};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL straddle_c: got %h want %h", got, want); end
    cyc(0, 0, 0, 0);
    got  = {valid, comp, pc, instr, imem_addr};
    want = {1'b1, 1'b0, 32'h2, 32'h0000_0513, 32'h8};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL straddle_32: got %h want %h", got, want); end
    cyc(0, 0, 0, 0);
    got  = {valid, comp, pc, instr, imem_addr};
    want = {1'b1, 1'b1, 32'h6, 32'h0000_4505, 32'h8};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL straddle_tail: got %h want %h", got, want); end
  endtask

  task automatic test_redirect();
    mem[6]  = 32'h4505_0001;
    mem[10] = 32'h0517_0001;
    mem[11] = 32'h0000_ABCF;
    cyc(0, 0, 1, 32'h1A);
    got  = {valid, 1'b0, 32'h0, instr, imem_addr};
    want = {1'b0, 1'b0, 32'h0, BUBBLE, 32'h18};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL redir_c_bubble: got %h want %h", got, want); end
    cyc(0, 0, 0, 0);
    got  = {valid, comp, pc, instr, imem_addr};
    want = {1'b1, 1'b1, 32'h1A, 32'h0000_4505, 32'h1C};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL redir_c_issue: got %h want %h", got, want); end
    cyc(0, 0, 1, 32'h2A);
    got  = {valid, 1'b0, 32'h0, instr, imem_addr};
    want = {1'b0, 1'b0, 32'h0, BUBBLE, 32'h28};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL redir_32_bubble1: got %h want %h", got, want); end
    cyc(0, 0, 0, 0);
    got  = {valid, 1'b0, 32'h0, instr, imem_addr};
    want = {1'b0, 1'b0, 32'h0, BUBBLE, 32'h2C};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL redir_32_bubble2: got %h want %h", got, want); end
    cyc(0, 0, 0, 0);
    got  = {valid, comp, pc, instr, imem_addr};
    want = {1'b1, 1'b0, 32'h2A, 32'hABCF_0517, 32'h30};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL redir_32_issue: got %h want %h", got, want); end
  endtask

  task automatic test_stall();
    mem[0] = 32'h4505_4501;
    mem[0] = 32'h0513_4501;
    mem[1] = 32'h4505_0093;
    mem[6] = 32'h4505_0001;
    do_reset();
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0);
      got  = {valid, comp, pc, instr, imem_addr};
      want = {1'b1, 1'b1, 32'h0, 32'h0000_4501, 32'h4};
      tests_run++;
      if (got !== want) begin failed++; $display("FAIL stall_hold_%0d: got %h want %h", i, got, want); end
    end
    cyc(0, 0, 0, 0);
    got  = {valid, comp, pc, instr, imem_addr};
    want = {1'b1, 1'b0, 32'h2, 32'h0093_0513, 32'h8};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL stall_release: got %h want %h", got, want); end
    cyc(1, 1, 0, 0);
    got  = {valid, 1'b0, 32'h0, instr, imem_addr};
    want = {1'b0, 1'b0, 32'h0, BUBBLE, 32'h8};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL stall_flush: got %h want %h", got, want); end
    cyc(0, 0, 0, 0);
    got  = {valid, comp, pc, instr, imem_addr};
    want = {1'b1, 1'b1, 32'h6, 32'h0000_4505, 32'h8};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL stall_flush_resume: got %h want %h", got, want); end
    cyc(1, 0, 1, 32'h1A);
    got  = {valid, 1'b0, 32'h0, instr, imem_addr};
    want = {1'b0, 1'b0, 32'h0, BUBBLE, 32'h18};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL stall_redirect: got %h want %h", got, want); end
    cyc(0, 0, 0, 0);
    got  = {valid, comp, pc, instr, imem_addr};
    want = {1'b1, 1'b1, 32'h1A, 32'h0000_4505, 32'h1C};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL stall_redirect_issue: got %h want %h", got, want); end
  endtask

  task automatic test_async_reset();
    mem[0] = 32'h0513_4501;
    mem[1] = 32'h4505_0093;
    do_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    got  = {valid, comp, pc, instr, imem_addr};
    want = {1'b0, 1'b0, 32'h0, BUBBLE, RESET_PC};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL async_reset: got %h want %h", got, want); end
    model_jump(RESET_PC);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    got  = {valid, comp, pc, instr, imem_addr};
    want = {1'b1, 1'b1, 32'h0, 32'h0000_4501, 32'h4};
    tests_run++;
    if (got !== want) begin failed++; $display("FAIL async_restart: got %h want %h", got, want); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [15:0] h [2];
    int errs;
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 2; k++) begin
        r = $urandom;
        if (r[16]) h[k] = {r[15:2], 2'b11};
        else       h[k] = {r[15:2], 2'($urandom_range(0, 2))};
      end
      mem[i] = {h[1], h[0]};
    end
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 19) == 0), $urandom);
      tests_run++;
      if (valid !== e_valid || instr !== e_instr ||
          (e_valid && (pc !== e_pc || comp !== e_c))) begin
        failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_%0d: got v=%b i=%h pc=%h c=%b want v=%b i=%h pc=%h c=%b",
                   n, valid, instr, pc, comp, e_valid, e_instr, e_pc, e_c);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    e_pc = 32'h0; e_c = 1'b0;
    test_reset();
    test_stream32();
    test_two_c();
    test_straddle();
    test_redirect();
    test_stall();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
